// File: rtl/card_pkg.sv
// card_pkg: shared definitions for the card shoe.
//   - shoe_state_t : controller state encoding (S_IDLE, S_FILL, S_PICK, S_PROBE)
//   - RANKS, CARDS_PER_DECK, ACE_VALUE, FACE_VALUE
//   - rank_value() : maps rank 1..13 to its blackjack value 2..11
package card_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_PICK  = 2'd2,
    S_PROBE = 2'd3
  } shoe_state_t;

  localparam int         RANKS          = 13;
  localparam int         CARDS_PER_DECK = 52;
  localparam logic [3:0] ACE_VALUE      = 4'd11;
  localparam logic [3:0] FACE_VALUE     = 4'd10;

  // Rank 1 is the ace, 11..13 are J/Q/K, everything else is face value.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    logic [3:0] value;
    if (rank == 4'd1) begin
      value = ACE_VALUE;
    end else if (rank >= 4'd11) begin
      value = FACE_VALUE;
    end else begin
      value = rank;
    end
    return value;
  endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// shoe_lfsr: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Also used by the dealer-card generator, so it stays self-contained.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-low reset, loads SEED
//   lfsr  out  current LFSR state (advances every clock)
// SEED must be nonzero or the register locks up at zero.
module shoe_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic feedback_s;

  assign feedback_s = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Shift left, feeding the tap XOR into bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback_s};
    end
  end

endmodule

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card source answering draw requests without replacement.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   draw_req     in   one-cycle draw request (ignored while busy)
//   shuffle_req  in   one-cycle refill request (ignored while busy)
//   card_valid   out  one-cycle pulse, card/card_rank valid
//   card         out  blackjack value 2..11
//   card_rank    out  rank 1..13 (1=ace, 11..13=J/Q/K)
//   cards_left   out  cards remaining in the shoe
//   busy         out  high whenever the controller is not idle
//   reshuffled   out  one-cycle pulse when a refill completes
// Build option: define SHOE_DETERMINISTIC_EN to start every draw at the ace,
// which deals the shoe in sorted order; the LFSR keeps running but is unused.
module card_shoe
  import card_pkg::*;
#(
  parameter int          NUM_DECKS      = 1,
  parameter int          RESHUFFLE_LEFT = 15,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [3:0] card,
  output logic [3:0] card_rank,
  output logic [7:0] cards_left,
  output logic       busy,
  output logic       reshuffled
);

  localparam logic [4:0] FULL_RANK = 5'(4 * NUM_DECKS);
  localparam logic [7:0] FULL_SHOE = 8'(CARDS_PER_DECK * NUM_DECKS);
  localparam logic [7:0] LOW_MARK  = 8'(RESHUFFLE_LEFT);

  shoe_state_t state_r;
  logic [3:0]  cand_r;
  logic        pend_draw_r;
  logic        valid_pend_r;
  logic [4:0]  count_r [RANKS];
  logic [15:0] lfsr_s;
  logic [3:0]  start_rank_s;
  logic        hit_s;
  logic        low_s;
  logic        unused_lfsr_s;

  shoe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr_s)
  );

`ifdef SHOE_DETERMINISTIC_EN
  assign start_rank_s  = 4'd0;
  assign unused_lfsr_s = ^lfsr_s;
`else
  // Fold 13..15 back onto 0..2 so any nibble names a legal rank index.
  assign start_rank_s  = (lfsr_s[3:0] >= 4'd13) ? (lfsr_s[3:0] - 4'd13) : lfsr_s[3:0];
  assign unused_lfsr_s = ^lfsr_s[15:4];
`endif

  assign low_s = (cards_left < LOW_MARK);

  // Does the current candidate rank still have a card left?
  always_comb begin
    hit_s = 1'b0;
    if (cand_r < 4'd13) begin
      hit_s = (count_r[cand_r] != 5'd0);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Controller: idle/fill/pick/probe sequencing, rank counters and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cand_r       <= 4'd0;
      pend_draw_r  <= 1'b0;
      valid_pend_r <= 1'b0;
      for (int i = 0; i < RANKS; i++) count_r[i] <= FULL_RANK;
      cards_left   <= FULL_SHOE;
      card_valid   <= 1'b0;
      card         <= 4'd0;
      card_rank    <= 4'd0;
      busy         <= 1'b0;
      reshuffled   <= 1'b0;
    end else begin
      // card/card_rank are loaded one cycle before the valid pulse.
      card_valid   <= valid_pend_r;
      valid_pend_r <= 1'b0;
      reshuffled   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (shuffle_req) begin
            pend_draw_r <= 1'b0;
            state_r     <= S_FILL;
            busy        <= 1'b1;
          end else if (draw_req) begin
            // Candidate is latched here even on the refill path.
            cand_r      <= start_rank_s;
            pend_draw_r <= low_s;
            state_r     <= low_s ? S_FILL : S_PICK;
            busy        <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_FILL: begin
          for (int i = 0; i < RANKS; i++) count_r[i] <= FULL_RANK;
          cards_left  <= FULL_SHOE;
          reshuffled  <= 1'b1;
          pend_draw_r <= 1'b0;
          state_r     <= pend_draw_r ? S_PICK : S_IDLE;
          busy        <= pend_draw_r;
        end
        S_PICK, S_PROBE: begin
          if (hit_s) begin
            count_r[cand_r] <= count_r[cand_r] - 5'd1;
            cards_left      <= cards_left - 8'd1;
            card_rank       <= cand_r + 4'd1;
            card            <= rank_value(cand_r + 4'd1);
            valid_pend_r    <= 1'b1;
            state_r         <= S_IDLE;
            busy            <= 1'b0;
          end else begin
            // Walk upward through the ranks; the shoe is never empty here.
            cand_r  <= (cand_r == 4'd12) ? 4'd0 : (cand_r + 4'd1);
            state_r <= S_PROBE;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed bench for card_shoe.
// Instance 0 uses RESHUFFLE_LEFT=15, instance 1 uses RESHUFFLE_LEFT=1; both one deck.
// A small shoe model predicts rank, value, latency, refills and cards_left
// for either build of SHOE_DETERMINISTIC_EN.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] draw_v = 2'b00;
  logic [1:0] shuf_v = 2'b00;
  logic [1:0] valid_v;
  logic [1:0] busy_v;
  logic [1:0] resh_v;
  logic [3:0] card_v  [2];
  logic [3:0] rank_v  [2];
  logic [7:0] left_v  [2];

  int checks = 0;
  int failures = 0;

  localparam int THR [2] = '{15, 1};

  int          m_cnt [2][13];
  int          m_left [2];
  logic [15:0] m_lfsr;
  int          hist [13];

  always #5 clk = ~clk;

  card_shoe #(.NUM_DECKS(1), .RESHUFFLE_LEFT(15), .LFSR_SEED(16'hACE1)) u_dut0 (
    .clk(clk), .reset(rst_n), .draw_req(draw_v[0]), .shuffle_req(shuf_v[0]),
    .card_valid(valid_v[0]), .card(card_v[0]), .card_rank(rank_v[0]),
    .cards_left(left_v[0]), .busy(busy_v[0]), .reshuffled(resh_v[0]));

  card_shoe #(.NUM_DECKS(1), .RESHUFFLE_LEFT(1), .LFSR_SEED(16'hACE1)) u_dut1 (
    .clk(clk), .reset(rst_n), .draw_req(draw_v[1]), .shuffle_req(shuf_v[1]),
    .card_valid(valid_v[1]), .card(card_v[1]), .card_rank(rank_v[1]),
    .cards_left(left_v[1]), .busy(busy_v[1]), .reshuffled(resh_v[1]));

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting toward the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_value(input int rank);
    case (rank)
      1:           return 11;
      11, 12, 13:  return 10;
      default:     return rank;
    endcase
  endfunction

  task automatic model_fill(input int k);
    for (int r = 0; r < 13; r++) m_cnt[k][r] = 4;
    m_left[k] = 52;
  endtask

  task automatic do_reset();
    draw_v = 2'b00;
    shuf_v = 2'b00;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_fill(0);
    model_fill(1);
  endtask

  // One draw on instance k; optionally pokes draw_req again while busy.
  task automatic do_draw(input int k, input bit poke, output int rank_out);
    int   cand, exp_lat, got_lat, seen;
    bit   exp_resh, seen_resh;
    logic [3:0] nib;
    @(negedge clk);
`ifdef SHOE_DETERMINISTIC_EN
    nib  = 4'd0;
    cand = 0;
`else
    nib  = m_lfsr[3:0];
    cand = (nib >= 4'd13) ? int'(nib) - 13 : int'(nib);
`endif
    exp_lat  = 2;
    exp_resh = 1'b0;
    if (m_left[k] < THR[k]) begin
      model_fill(k);
      exp_lat++;
      exp_resh = 1'b1;
    end
    while (m_cnt[k][cand] == 0) begin
      cand = (cand + 1) % 13;
      exp_lat++;
    end
    m_cnt[k][cand]--;
    m_left[k]--;
    draw_v[k] = 1'b1;
    @(posedge clk); #1;
    draw_v[k] = 1'b0;
    if (poke) check_val("busy_in_draw", int'(busy_v[k]), 1);
    got_lat = 0;
    seen_resh = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (poke && n == 1) draw_v[k] = 1'b1;
      @(posedge clk); #1;
      draw_v[k] = 1'b0;
      if (resh_v[k]) seen_resh = 1'b1;
      if (valid_v[k]) begin
        got_lat = n;
        break;
      end
    end
    check_val("latency", got_lat, exp_lat);
    check_val("reshuffled", int'(seen_resh), int'(exp_resh));
    check_val("card_rank", int'(rank_v[k]), cand + 1);
    check_val("card", int'(card_v[k]), exp_value(cand + 1));
    check_val("cards_left", int'(left_v[k]), m_left[k]);
    rank_out = int'(rank_v[k]);
    if (poke) begin
      seen = 0;
      for (int n = 0; n < 16; n++) begin
        @(posedge clk); #1;
        if (valid_v[k]) seen++;
      end
      check_val("busy_draw_ignored", seen, 0);
      check_val("left_after_ignore", int'(left_v[k]), m_left[k]);
    end
  endtask

  initial begin
    int r, seen_v, seen_r;
    do_reset();
    #1;
    // Reset state
    check_val("rst_card_valid", int'(valid_v[0]), 0);
    check_val("rst_card", int'(card_v[0]), 0);
    check_val("rst_card_rank", int'(rank_v[0]), 0);
    check_val("rst_cards_left", int'(left_v[0]), 52);
    check_val("rst_busy", int'(busy_v[0]), 0);
    check_val("rst_reshuffled", int'(resh_v[0]), 0);
    repeat (6) @(posedge clk);

    // 40 draws: first aces, first probe, low-shoe refill on the 39th
    for (int i = 0; i < 40; i++) begin
      do_draw(0, (i == 2), r);
`ifdef SHOE_DETERMINISTIC_EN
      if (i == 0) check_val("det_first_ace", r, 1);
      if (i == 4) check_val("det_fifth_is_two", r, 2);
`endif
    end

    // shuffle_req beats a simultaneous draw_req
    @(negedge clk);
    shuf_v[0] = 1'b1;
    draw_v[0] = 1'b1;
    @(posedge clk); #1;
    shuf_v[0] = 1'b0;
    draw_v[0] = 1'b0;
    seen_v = 0;
    seen_r = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (valid_v[0]) seen_v++;
      if (resh_v[0]) seen_r++;
    end
    check_val("shuf_reshuffled", seen_r, 1);
    check_val("shuf_no_card", seen_v, 0);
    check_val("shuf_cards_left", int'(left_v[0]), 52);
    model_fill(0);
    do_draw(0, 1'b0, r);

    // Reset in the middle of a draw aborts it
    do_reset();
    for (int i = 0; i < 4; i++) do_draw(0, 1'b0, r);
    @(negedge clk);
    draw_v[0] = 1'b1;
    @(posedge clk); #1;
    draw_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_val("abort_cards_left", int'(left_v[0]), 52);
    @(negedge clk);
    rst_n = 1'b1;
    model_fill(0);
    model_fill(1);
    seen_v = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if (valid_v[0]) seen_v++;
    end
    check_val("abort_no_card", seen_v, 0);

    // Whole deck on the RESHUFFLE_LEFT=1 shoe: every rank exactly four times
    do_reset();
    for (int i = 0; i < 13; i++) hist[i] = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw(1, 1'b0, r);
      if (r >= 1 && r <= 13) hist[r - 1]++;
`ifdef SHOE_DETERMINISTIC_EN
      if (i == 48) check_val("det_49th_king", r, 13);
`endif
    end
    for (int i = 0; i < 13; i++) check_val($sformatf("rank%0d_count", i + 1), hist[i], 4);
    check_val("deck_empty", int'(left_v[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Card source for the blackjack game FSM: the responder end of the hit/card interface.
- Holds NUM_DECKS 52-card decks and answers each draw request with one card drawn without replacement.
- Tracks cards remaining per rank and reshuffles when the shoe runs low or on request.
- Card value encoding matches the game FSM: ace=11, 2..10 face value, J/Q/K=10.

Parameters:
- NUM_DECKS, 1, decks in shoe; legal 1..4.
- RESHUFFLE_LEFT, 15, auto-reshuffle threshold; legal 1..(52*NUM_DECKS-1).
- LFSR_SEED, 16'hACE1, reset value of the rank-pick LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- draw_req  in  1  single-cycle draw request pulse (already edge-detected).
- shuffle_req  in  1  single-cycle pulse; refill the shoe.
- card_valid  out  1  one-cycle pulse; card and card_rank are valid.
- card  out  4  blackjack value 2..11.
- card_rank  out  4  rank 1..13 (1=ace, 11..13=J/Q/K).
- cards_left  out  8  cards remaining in the shoe.
- busy  out  1  high in any state other than S_IDLE.
- reshuffled  out  1  one-cycle pulse when a refill completes.

Behaviour:
- Reset (reset=0):
  - state S_IDLE; all 13 rank counters = 4*NUM_DECKS; cards_left = 52*NUM_DECKS; LFSR = LFSR_SEED.
  - card_valid=0, card=0, card_rank=0, busy=0, reshuffled=0.
  - Reset mid-draw aborts the draw; no card_valid is issued.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clock, including while busy.
- Rank counters: 13 x 5 bits; cards_left = sum of the counters, held in a dedicated 8-bit register.
- State S_IDLE:
  - shuffle_req=1 -> S_FILL. shuffle_req wins over a simultaneous draw_req; that draw is dropped.
  - draw_req=1 and cards_left < RESHUFFLE_LEFT -> S_FILL, with a pending-draw flag set.
  - draw_req=1 otherwise -> S_PICK. The candidate rank is latched as lfsr[3:0], minus 13 when that value is >=13, giving 0..12.
- State S_FILL (1 cycle):
  - Reload all counters and cards_left; pulse reshuffled.
  - If the pending-draw flag is set -> S_PICK; otherwise -> S_IDLE.
- State S_PICK / S_PROBE:
  - If count[candidate] != 0: decrement count[candidate] and cards_left, register card_rank=candidate+1 and the mapped card, pulse card_valid next cycle, -> S_IDLE.
  - Otherwise: candidate = (candidate+1) mod 13, -> S_PROBE, one probe per cycle.
- Latency (draw_req sampled edge to card_valid high):
  - Minimum 2 cycles; each extra probe adds 1; maximum 14 cycles. An auto-reshuffle adds 1.
  - The shoe can never be empty at pick time because RESHUFFLE_LEFT >= 1.
- draw_req or shuffle_req while busy=1: ignored, not queued.
- card and card_rank hold their last value between card_valid pulses.

Optional Feature:
- Macro: SHOE_DETERMINISTIC_EN.
  - Defined: the S_IDLE candidate is always rank index 0 (ace), so draws come out in sorted order (4*NUM_DECKS aces, then 2s, and so on). Used for repeatable benches. The LFSR still runs but is unused.
  - Undefined: LFSR candidate as described in Behaviour.
- All other behaviour is identical either way.

Decomposition:
- Package card_pkg holds:
  - state encodings S_IDLE, S_FILL, S_PICK, S_PROBE;
  - constants RANKS=13, CARDS_PER_DECK=52, ACE_VALUE=11, FACE_VALUE=10;
  - the rank-to-value mapping function.
- One sub-module, shoe_lfsr (16-bit LFSR with seed parameter), shared with the dealer-card generator.

Test Plan:
All scenarios run with SHOE_DETERMINISTIC_EN defined, NUM_DECKS=1, RESHUFFLE_LEFT=15 unless noted.
1. Reset, then draw_req at cycle 10 -> card_valid at cycle 12, card=11, card_rank=1, cards_left=51.
2. Draws 1..4 -> all aces. Draw 5 -> card=2, card_rank=2, latency 3 (one probe).
3. Draws up to the 38th succeed; cards_left=14 after the 38th. The 39th draw -> reshuffled pulse, then card_valid with card=11 (aces restored), cards_left=51, latency 3.
4. RESHUFFLE_LEFT=1, 49th draw (ranks 1..12 empty) -> card_rank=13, card=10, latency 14.
5. shuffle_req and draw_req in the same cycle in S_IDLE -> reshuffled pulse, no card_valid, cards_left=52. A draw_req issued while busy -> ignored.
6. reset asserted during S_PROBE -> card_valid stays 0, cards_left=52. Macro undefined with seed 16'hACE1: 52 draws (RESHUFFLE_LEFT=1) -> each rank appears exactly 4 times.
